// File: rtl/tinyqv_instr_aligner.sv
// rtl/tinyqv_instr_aligner.sv - halfword alignment buffer between TinyQV fetch and decode
// Optional same-cycle bypass of an empty buffer is enabled by defining TQV_ALIGNER_BYPASS_EN.
module tinyqv_instr_aligner #(
  parameter int FETCH_HW = 2,
  parameter int DEPTH_HW = 8,
  parameter int PC_BITS  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [PC_BITS-2:0]        flush_pc,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [16*FETCH_HW-1:0]    fetch_data,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [1:0]                instr_len,
  output logic [PC_BITS-2:0]        instr_pc,
  output logic [$clog2(DEPTH_HW):0] level
);
  localparam int AW = $clog2(DEPTH_HW);
  localparam int LW = AW + 1;
  localparam int PW = PC_BITS - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH_HW);
  localparam logic [LW-1:0] FETCH_L = LW'(FETCH_HW);

  logic [15:0]   r_mem [DEPTH_HW];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [LW-1:0] r_count;
  logic [PW-1:0] r_pc;
  logic          r_drop;

  logic [31:0] w_beat;
  logic [31:0] w_shift;
  logic [15:0] w_h0;
  logic [15:0] w_h1;
  logic        w_buf_comp;
  logic        w_buf_valid;
  logic        w_bp_comp;
  logic        w_bp_ok;
  logic        w_bp_take;
  logic [1:0]  w_buf_len;
  logic [1:0]  w_bp_len;
  logic [1:0]  w_len;
  logic [1:0]  w_skip;
  logic [1:0]  w_nwr;
  logic        w_push;
  logic        w_pop;
  logic        w_pop_buf;

  assign w_beat      = 32'(fetch_data);
  assign w_h0        = r_mem[r_rd];
  assign w_h1        = r_mem[r_rd + AW'(1)];
  assign w_buf_comp  = (w_h0[1:0] != 2'b11);
  assign w_buf_valid = ((r_count >= LW'(1)) && w_buf_comp) || ((r_count >= LW'(2)) && !w_buf_comp);
  assign w_buf_len   = w_buf_comp ? 2'd1 : 2'd2;
  assign w_bp_comp   = (w_beat[1:0] != 2'b11);
  assign w_bp_len    = w_bp_comp ? 2'd1 : 2'd2;

`ifdef TQV_ALIGNER_BYPASS_EN
  // A 32-bit instruction can only bypass when the whole of it arrives in one beat.
  assign w_bp_ok = (r_count == '0) && !r_drop && fetch_valid && !flush &&
                   (w_bp_comp || (FETCH_HW == 2));
`else
  assign w_bp_ok = 1'b0;
`endif

  assign instr_valid = w_buf_valid || w_bp_ok;
  assign w_len       = w_bp_ok ? w_bp_len : w_buf_len;
  assign instr_len   = w_len;
  assign instr_pc    = r_pc;
  assign level       = r_count;

  always_comb begin
    instr = 32'h0000_0000;
    if (w_bp_ok) begin
      instr = w_bp_comp ? {16'h0000, w_beat[15:0]} : w_beat;
    end else begin
      instr = w_buf_comp ? {16'h0000, w_h0} : {w_h1, w_h0};
    end
  end

  // Space is judged on the registered count only; a pop this cycle frees room next cycle.
  assign fetch_ready = ((DEPTH_L - r_count) >= FETCH_L) && !flush;

  assign w_push    = fetch_valid && fetch_ready;
  assign w_pop     = instr_valid && instr_ready;
  assign w_pop_buf = w_buf_valid && instr_ready;
  assign w_bp_take = w_bp_ok && instr_ready;

  // Leading halfwords of the beat that are not stored: a misaligned redirect target
  // or an instruction already handed straight to the decoder.
  assign w_skip  = r_drop ? 2'd1 : (w_bp_take ? w_bp_len : 2'd0);
  assign w_nwr   = 2'(FETCH_HW) - w_skip;
  assign w_shift = w_beat >> {w_skip, 4'b0000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_drop  <= 1'b0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_pc    <= flush_pc;
      r_drop  <= (FETCH_HW == 2) && flush_pc[0];
    end else begin
      if (w_push) begin
        r_wr   <= r_wr + AW'(w_nwr);
        r_drop <= 1'b0;
      end
      if (w_pop_buf) begin
        r_rd <= r_rd + AW'(w_len);
      end
      if (w_pop) begin
        r_pc <= r_pc + PW'(w_len);
      end
      r_count <= r_count + (w_push ? LW'(w_nwr) : LW'(0)) - (w_pop_buf ? LW'(w_len) : LW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      for (int k = 0; k < FETCH_HW; k++) begin
        if (2'(k) < w_nwr) begin
          r_mem[r_wr + AW'(k)] <= w_shift[16*k +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_instr_aligner.sv
// tb/tb_tinyqv_instr_aligner.sv - directed and randomized check of the aligner against a halfword-queue model
module tb_tinyqv_instr_aligner;
  localparam int PB = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [PB-2:0] flush_pc;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [1:0]    instr_len;
  logic [PB-2:0] instr_pc;
  logic [3:0]    level;

  tinyqv_instr_aligner #(.FETCH_HW(2), .DEPTH_HW(8), .PC_BITS(PB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_len(instr_len), .instr_pc(instr_pc), .level(level)
  );

  always #5 clk = ~clk;

  logic [15:0]   q[$];
  logic [PB-1:0] m_pc;
  bit            m_drop;
  int            n_vec;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit fv, input logic [31:0] d, input bit ir,
                      input bit fl, input logic [PB-2:0] fpc, input bit r);
    logic [15:0] s[$];
    logic [15:0] beat[$];
    logic [31:0] exp_instr;
    bit bp;
    bit head_c;
    bit ev;
    bit er;
    int len;
    rst = r; flush = fl; flush_pc = fpc;
    fetch_valid = fv; fetch_data = d; instr_ready = ir;
    #1;
    s = q;
    beat.delete();
    beat.push_back(d[15:0]);
    beat.push_back(d[31:16]);
    bp = 1'b0;
`ifdef TQV_ALIGNER_BYPASS_EN
    if (q.size() == 0 && !m_drop && fv && !fl) begin
      s = beat;
      bp = 1'b1;
    end
`endif
    head_c = 1'b0;
    if (s.size() >= 1) head_c = (s[0][1:0] != 2'b11);
    ev  = (s.size() >= 1 && head_c) || (s.size() >= 2);
    len = head_c ? 1 : 2;
    er  = ((8 - q.size()) >= 2) && !fl;
    check("valid", 32'(instr_valid), 32'(ev));
    check("ready", 32'(fetch_ready), 32'(er));
    check("level", 32'(level), 32'(q.size()));
    check("pc", 32'(instr_pc), 32'(m_pc[PB-1:1]));
    if (ev) begin
      exp_instr = (len == 1) ? {16'h0000, s[0]} : {s[1], s[0]};
      check("len", 32'(instr_len), 32'(len));
      check("instr", instr, exp_instr);
    end
    if (r) begin
      q.delete(); m_pc = '0; m_drop = 1'b0;
    end else if (fl) begin
      q.delete(); m_pc = {fpc, 1'b0}; m_drop = fpc[0];
    end else begin
      if (ev && ir) begin
        m_pc = m_pc + PB'(2 * len);
        if (bp) begin
          repeat (len) void'(beat.pop_front());
          q = beat;
        end else begin
          repeat (len) void'(q.pop_front());
        end
      end
      if (!(bp && ev && ir) && fv && er) begin
        if (m_drop) begin
          void'(beat.pop_front());
          m_drop = 1'b0;
        end
        foreach (beat[i]) q.push_back(beat[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d, input bit ir);
    step(1'b1, d, ir, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input bit ir);
    step(1'b0, 32'h0, ir, 1'b0, '0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  bit          r_fv;
  bit          r_ir;
  bit          r_fl;
  bit          r_rs;
  int          phase;
  logic [31:0] r_d;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; flush = 1'b0; flush_pc = '0; fetch_valid = 1'b0;
    fetch_data = '0; instr_ready = 1'b0;
    q.delete(); m_pc = '0; m_drop = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_pc", 32'(instr_pc), 32'd0);

    // Two C.NOP-style halfwords in one beat.
    push(32'h0001_4501, 1'b0);
    check("nop0_instr", instr, 32'h0000_4501);
    check("nop0_pc", 32'(instr_pc), 32'd0);
    idle(1'b1);
    check("nop1_instr", instr, 32'h0000_0001);
    check("nop1_pc", 32'(instr_pc), 32'd1);
    idle(1'b1);
    check("nop_level", 32'(level), 32'd0);
    check("nop_pc_end", 32'(instr_pc), 32'd2);

    // 32-bit instruction straddling two beats.
    do_rst();
    push(32'h0293_0001, 1'b0);
    check("str_c", instr, 32'h0000_0001);
    idle(1'b1);
    check("str_half_valid", 32'(instr_valid), 32'd0);
    check("str_half_level", 32'(level), 32'd1);
    push(32'h0000_0050, 1'b1);
    check("str_valid", 32'(instr_valid), 32'd1);
    check("str_instr", instr, 32'h0050_0293);
    check("str_len", 32'(instr_len), 32'd2);
    check("str_pc", 32'(instr_pc), 32'd1);
    idle(1'b1);
    check("str_pc_next", 32'(instr_pc), 32'd3);
    idle(1'b1);

    // Flush to byte 0x102: leading halfword of the next beat is dropped.
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 23'h81, 1'b0);
    check("fl_level", 32'(level), 32'd0);
    check("fl_valid", 32'(instr_valid), 32'd0);
    check("fl_pc", 32'(instr_pc), 32'h81);
    push(32'h4501_ABCD, 1'b0);
    check("fl_drop_level", 32'(level), 32'd1);
    check("fl_drop_instr", instr, 32'h0000_4501);
    idle(1'b1);
    check("fl_pc_next", 32'(instr_pc), 32'h82);

    // Fill to full, then drain until a beat fits again.
    do_rst();
    for (int i = 0; i < 4; i++) push(32'h1101_1001 + 32'h0020_0020 * i, 1'b0);
    check("full_level", 32'(level), 32'd8);
    check("full_ready", 32'(fetch_ready), 32'd0);
    push(32'h5555_5555, 1'b1);
    check("full_pop_level", 32'(level), 32'd7);
    check("full_pop_ready", 32'(fetch_ready), 32'd0);
    idle(1'b1);
    idle(1'b1);
    check("refill_level", 32'(level), 32'd5);
    check("refill_ready", 32'(fetch_ready), 32'd1);

    // Push and 32-bit pop together, then reset mid-stream.
    do_rst();
    push(32'h0050_0293, 1'b0);
    push(32'h4501_4501, 1'b1);
    check("sim_level", 32'(level), 32'd2);
    step(1'b1, 32'h4501_4501, 1'b1, 1'b0, '0, 1'b1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", 32'(instr_pc), 32'd0);

    // Empty buffer with the decoder ready.
    push(32'h0000_4501, 1'b1);
`ifdef TQV_ALIGNER_BYPASS_EN
    check("bp_level", 32'(level), 32'd1);
    check("bp_pc", 32'(instr_pc), 32'd1);
`else
    check("nobp_level", 32'(level), 32'd2);
    check("nobp_valid", 32'(instr_valid), 32'd1);
`endif

    for (int c = 0; c < 4000; c++) begin
      phase = (c / 150) % 3;
      r_d  = $urandom;
      r_fv = (phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_ir = (phase == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 40) == 0);
      r_rs = ($urandom_range(0, 400) == 0);
      step(r_fv, r_d, r_ir, r_fl, 23'($urandom), r_rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
